intra_block_sequencer: RTL and testbench
========================================

Name: intra_block_sequencer

Overview:
Parametrised stage sequencer for the intra 8x8 / chroma residual path. It generalises the fixed-count chroma controller in four ways:
- block count per component is a parameter, covering 4:2:0 (4 blocks) and 4:2:2 (8 blocks);
- component count is a parameter;
- stage lengths are parameters;
- input words, block index and component index are counted internally.

It also adds a feedback-wait timeout and sticky error flags. It sits between the input word stream and the transform/quant/output datapath and drives one enable per pipeline phase.

Parameters:
- IN_WORDS, 16: input strobes per component before processing starts.
- NUM_BLOCKS, 4: blocks per component; power of 2, range 2..16.
- NUM_COMP, 2: components per macroblock (cb, cr); range 1..4.
- PRE_STAGES, 3: setup cycles after input.
- XFORM_STAGES, 4: transform cycles per block.
- OUT_STAGES, 6: output cycles per block.
- FB_TIMEOUT, 64: maximum cycles spent waiting on feedback.

Ports:
- CLK2  in  1  clock
- NEWLINE  in  1  synchronous active-high reset
- STROBEI  in  1  input word valid
- READYO  in  1  downstream ready for the next block
- FBSTROBE  in  1  feedback transfer in progress
- fbpending  in  1  feedback outstanding
- en_load  out  1  input word accepted this cycle
- en_pre  out  1  setup phase
- en_xform  out  1  transform phase
- en_wait  out  1  waiting for READYO
- en_out  out  1  output phase
- en_fb  out  1  feedback wait phase
- sub_step  out  4  step index within PRE, XFORM or OUT
- blk_idx  out  max(1,clog2(NUM_BLOCKS))  current block
- comp_idx  out  max(1,clog2(NUM_COMP))  current component
- busy  out  1  high in any state other than LOAD
- done  out  1  one-cycle pulse, all components finished
- fb_timeout  out  1  sticky: a feedback timeout occurred
- in_overrun  out  1  sticky: STROBEI seen outside LOAD

Behaviour:
- Clock and reset:
  - One clock, CLK2. Reset is synchronous and active-high on NEWLINE, sampled at posedge CLK2.
  - Reset overrides everything, including mid-operation. It sets: state=LOAD; word counter, sub_step, blk_idx, comp_idx and timeout counter to 0; all enables, busy, done, fb_timeout and in_overrun to 0.
- States: LOAD, PRE, XFORM, WAITO, OUT, FB, DONE. Outputs are Moore-decoded from registered state and counters, except en_load.
- LOAD:
  - en_load = STROBEI (combinational).
  - Each STROBEI increments the word counter.
  - The strobe that makes the count IN_WORDS moves the FSM to PRE and clears the counter.
- PRE:
  - en_pre=1 for PRE_STAGES cycles; sub_step = 0..PRE_STAGES-1.
  - Then XFORM with blk_idx=0.
- XFORM:
  - en_xform=1; sub_step runs 0..XFORM_STAGES-1 per block.
  - After the last step, blk_idx increments.
  - After block NUM_BLOCKS-1, blk_idx wraps to 0 and the FSM goes to WAITO.
  - First en_xform is exactly PRE_STAGES+1 cycles after the cycle of the last input strobe.
- WAITO:
  - en_wait=1; minimum occupancy is 1 cycle.
  - READYO sampled high moves the FSM to OUT on the next edge; otherwise it stays.
- OUT: en_out=1 for OUT_STAGES cycles, then FB.
- FB:
  - en_fb=1; the timeout counter increments every FB cycle.
  - While fbpending|FBSTROBE is high, stay, unless the counter reaches FB_TIMEOUT-1. In that case set fb_timeout and exit as if clear.
  - On exit, clear the timeout counter, then advance:
    - if blk_idx != NUM_BLOCKS-1: blk_idx+1, go to WAITO;
    - else if comp_idx != NUM_COMP-1: comp_idx+1, blk_idx=0, go to LOAD;
    - else go to DONE.
- DONE: done=1 for one cycle; comp_idx=0; then LOAD.
- Exactly one of en_pre, en_xform, en_wait, en_out, en_fb and done is high at a time; all of them are low in LOAD.
- STROBEI in any state other than LOAD: the word is ignored and in_overrun is set. Counters are unaffected.
- sub_step reads 0 outside PRE, XFORM and OUT.
- blk_idx and comp_idx wrap only as specified above; no other wrap-around.
- Simultaneous events:
  - READYO and fbpending have no effect outside WAITO and FB respectively.
  - NEWLINE together with any other input: reset wins.
- Unreachable state encodings recover to LOAD on the next cycle.

Test Plan (default parameters; cycle 0 = first STROBEI):
1. 32 continuous strobes, split 16+16 across components; READYO=1; fbpending=FBSTROBE=0.
   - Component 0: en_pre cycles 16-18; en_xform cycles 19-34; blocks 0..3 each see wait=1, out=6, fb=1 cycles (cycles 35-66).
   - Component 1 repeats the pattern over cycles 67-133; done pulses at cycle 134.
   - No error flags set.
2. READYO held low for 10 cycles at the WAITO of block 2 → en_wait high for 11 cycles; blk_idx stays 2; en_out starts the cycle after READYO rises.
3. fbpending high for 5 cycles at FB entry of block 1 → en_fb high for 6 cycles, then blk_idx=2 and en_wait=1.
4. fbpending stuck high → en_fb high for exactly 64 cycles; fb_timeout=1 and stays 1; the sequence continues to the next block.
5. NEWLINE pulsed at cycle 25 (mid-XFORM) → from cycle 26 all outputs are 0, blk_idx=0, comp_idx=0; 16 new strobes restart PRE exactly as in scenario 1.
6. STROBEI pulsed during OUT → in_overrun=1; sub_step, blk_idx and the timing of scenario 1 are unchanged.
7. NUM_BLOCKS=8 build → blk_idx reaches 7 and each component has 32 XFORM cycles.

Source files
------------

// File: rtl/intra_block_sequencer.sv
// intra_block_sequencer
//   Stage sequencer for the intra 8x8 / chroma residual path. It counts the
//   input words of a component, then for that component runs setup, a
//   transform of every block, and per block a wait for downstream, an output
//   burst and a feedback wait. After the last component it pulses done.
//
// Ports
//   CLK2        clock
//   NEWLINE     synchronous active-high reset
//   STROBEI     input word valid
//   READYO      downstream ready for the next block
//   FBSTROBE    feedback transfer in progress
//   fbpending   feedback outstanding
//   en_load     input word accepted this cycle
//   en_pre      setup phase
//   en_xform    transform phase
//   en_wait     waiting for READYO
//   en_out      output phase
//   en_fb       feedback wait phase
//   sub_step    step index within PRE, XFORM or OUT (0 elsewhere)
//   blk_idx     current block
//   comp_idx    current component
//   busy        high in any state other than LOAD
//   done        one-cycle pulse, all components finished
//   fb_timeout  sticky: a feedback wait hit its cycle limit
//   in_overrun  sticky: STROBEI seen outside LOAD
//   state_dbg   raw FSM state, for observation only
//
// Handshake: STROBEI is a valid with no ready; a word is taken only while the
// FSM is in LOAD (en_load marks the taken words). READYO is sampled only in
// WAITO, fbpending/FBSTROBE only in FB; elsewhere they are ignored.
module intra_block_sequencer #(
  parameter int IN_WORDS     = 16,
  parameter int NUM_BLOCKS   = 4,
  parameter int NUM_COMP     = 2,
  parameter int PRE_STAGES   = 3,
  parameter int XFORM_STAGES = 4,
  parameter int OUT_STAGES   = 6,
  parameter int FB_TIMEOUT   = 64,
  localparam int BW = (NUM_BLOCKS > 2) ? $clog2(NUM_BLOCKS) : 1,
  localparam int CW = (NUM_COMP > 2)   ? $clog2(NUM_COMP)   : 1,
  localparam int WW = (IN_WORDS > 2)   ? $clog2(IN_WORDS)   : 1,
  localparam int TW = (FB_TIMEOUT > 2) ? $clog2(FB_TIMEOUT) : 1
) (
  input  logic          CLK2,
  input  logic          NEWLINE,
  input  logic          STROBEI,
  input  logic          READYO,
  input  logic          FBSTROBE,
  input  logic          fbpending,
  output logic          en_load,
  output logic          en_pre,
  output logic          en_xform,
  output logic          en_wait,
  output logic          en_out,
  output logic          en_fb,
  output logic [3:0]    sub_step,
  output logic [BW-1:0] blk_idx,
  output logic [CW-1:0] comp_idx,
  output logic          busy,
  output logic          done,
  output logic          fb_timeout,
  output logic          in_overrun,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_PRE   = 3'd1,
    S_XFORM = 3'd2,
    S_WAITO = 3'd3,
    S_OUT   = 3'd4,
    S_FB    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] word_q, word_d;
  logic [3:0]    step_q, step_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [CW-1:0] comp_q, comp_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          fb_timeout_q, in_overrun_q;
  logic          set_tmo;
  logic          fb_busy;

  assign fb_busy = fbpending | FBSTROBE;

  always_ff @(posedge CLK2) begin
    if (NEWLINE) begin
      state_q      <= S_LOAD;
      word_q       <= '0;
      step_q       <= '0;
      blk_q        <= '0;
      comp_q       <= '0;
      tmo_q        <= '0;
      fb_timeout_q <= 1'b0;
      in_overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      step_q  <= step_d;
      blk_q   <= blk_d;
      comp_q  <= comp_d;
      tmo_q   <= tmo_d;
      if (set_tmo)
        fb_timeout_q <= 1'b1;
      if (STROBEI && (state_q != S_LOAD))
        in_overrun_q <= 1'b1;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    step_d  = step_q;
    blk_d   = blk_q;
    comp_d  = comp_q;
    tmo_d   = tmo_q;
    set_tmo = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (STROBEI) begin
          if (word_q == WW'(IN_WORDS - 1)) begin
            word_d  = '0;
            step_d  = '0;
            state_d = S_PRE;
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end
      S_PRE: begin
        if (step_q == 4'(PRE_STAGES - 1)) begin
          step_d  = '0;
          blk_d   = '0;
          state_d = S_XFORM;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      S_XFORM: begin
        if (step_q == 4'(XFORM_STAGES - 1)) begin
          step_d = '0;
          if (blk_q == BW'(NUM_BLOCKS - 1)) begin
            blk_d   = '0;
            state_d = S_WAITO;
          end else begin
            blk_d = blk_q + BW'(1);
          end
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      S_WAITO: begin
        if (READYO) begin
          step_d  = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (step_q == 4'(OUT_STAGES - 1)) begin
          step_d  = '0;
          tmo_d   = '0;
          state_d = S_FB;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      S_FB: begin
        if (fb_busy && (tmo_q != TW'(FB_TIMEOUT - 1))) begin
          tmo_d = tmo_q + TW'(1);
        end else begin
          // Either feedback cleared or the wait ran out; both leave FB.
          set_tmo = fb_busy;
          tmo_d   = '0;
          if (blk_q != BW'(NUM_BLOCKS - 1)) begin
            blk_d   = blk_q + BW'(1);
            state_d = S_WAITO;
          end else if (comp_q != CW'(NUM_COMP - 1)) begin
            comp_d  = comp_q + CW'(1);
            blk_d   = '0;
            state_d = S_LOAD;
          end else begin
            comp_d  = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        comp_d  = '0;
        state_d = S_LOAD;
      end
      default: begin
        // Unused encoding: fall back to a clean LOAD.
        word_d  = '0;
        step_d  = '0;
        tmo_d   = '0;
        state_d = S_LOAD;
      end
    endcase
  end

  // Moore output decode (en_load also follows STROBEI directly)
  always_comb begin
    en_load  = 1'b0;
    en_pre   = 1'b0;
    en_xform = 1'b0;
    en_wait  = 1'b0;
    en_out   = 1'b0;
    en_fb    = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;
    sub_step = 4'd0;
    case (state_q)
      S_LOAD:  en_load = STROBEI & ~NEWLINE;
      S_PRE:   begin en_pre   = 1'b1; busy = 1'b1; sub_step = step_q; end
      S_XFORM: begin en_xform = 1'b1; busy = 1'b1; sub_step = step_q; end
      S_WAITO: begin en_wait  = 1'b1; busy = 1'b1; end
      S_OUT:   begin en_out   = 1'b1; busy = 1'b1; sub_step = step_q; end
      S_FB:    begin en_fb    = 1'b1; busy = 1'b1; end
      S_DONE:  begin done     = 1'b1; busy = 1'b1; end
      default: busy = 1'b1;
    endcase
  end

  assign blk_idx    = blk_q;
  assign comp_idx   = comp_q;
  assign fb_timeout = fb_timeout_q;
  assign in_overrun = in_overrun_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_intra_block_sequencer.sv
// Directed bench for intra_block_sequencer. Each scenario starts from reset;
// cycle 0 is the first cycle after reset release. Every cycle the outputs
// are captured into a trace, and the scenario's expectations (hand-derived
// cycle numbers) are compared against the trace afterwards.
module tb_intra_block_sequencer;

  localparam int NC = 200;

  // clock / reset
  logic CLK2 = 1'b0;
  always #5 CLK2 = ~CLK2;

  logic NEWLINE, STROBEI, READYO, FBSTROBE, fbpending;
  logic en_load, en_pre, en_xform, en_wait, en_out, en_fb;
  logic [3:0] sub_step;
  logic [1:0] blk_idx;
  logic [0:0] comp_idx;
  logic busy, done, fb_timeout, in_overrun;
  logic [2:0] state_dbg;

  // NUM_BLOCKS=8 build, fed with the same inputs
  logic en_load8, en_pre8, en_xform8, en_wait8, en_out8, en_fb8;
  logic [3:0] sub_step8;
  logic [2:0] blk_idx8;
  logic [0:0] comp_idx8;
  logic busy8, done8, fb_timeout8, in_overrun8;
  logic [2:0] state_dbg8;

  intra_block_sequencer dut (
    .CLK2(CLK2), .NEWLINE(NEWLINE), .STROBEI(STROBEI), .READYO(READYO),
    .FBSTROBE(FBSTROBE), .fbpending(fbpending),
    .en_load(en_load), .en_pre(en_pre), .en_xform(en_xform),
    .en_wait(en_wait), .en_out(en_out), .en_fb(en_fb),
    .sub_step(sub_step), .blk_idx(blk_idx), .comp_idx(comp_idx),
    .busy(busy), .done(done), .fb_timeout(fb_timeout),
    .in_overrun(in_overrun), .state_dbg(state_dbg)
  );

  intra_block_sequencer #(.NUM_BLOCKS(8)) dut8 (
    .CLK2(CLK2), .NEWLINE(NEWLINE), .STROBEI(STROBEI), .READYO(READYO),
    .FBSTROBE(FBSTROBE), .fbpending(fbpending),
    .en_load(en_load8), .en_pre(en_pre8), .en_xform(en_xform8),
    .en_wait(en_wait8), .en_out(en_out8), .en_fb(en_fb8),
    .sub_step(sub_step8), .blk_idx(blk_idx8), .comp_idx(comp_idx8),
    .busy(busy8), .done(done8), .fb_timeout(fb_timeout8),
    .in_overrun(in_overrun8), .state_dbg(state_dbg8)
  );

  // trace bits: 0 busy,1 load,2 pre,3 xform,4 wait,5 out,6 fb,7 done,8 fbto,9 ovr
  localparam int B_BUSY = 0, B_LOAD = 1, B_PRE = 2, B_XF = 3, B_WAIT = 4;
  localparam int B_OUT = 5, B_FB = 6, B_DONE = 7, B_TMO = 8, B_OVR = 9;

  logic [9:0] tr_bits [NC];
  int tr_blk [NC];
  int tr_comp [NC];
  int tr_sub [NC];
  int x8_cnt, x8_max;
  int n_cmp = 0;
  int n_bad = 0;

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] snap();
    return {in_overrun, fb_timeout, done, en_fb, en_out, en_wait,
            en_xform, en_pre, en_load, busy};
  endfunction

  function automatic int cnt(input int b, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(tr_bits[i][b]);
    return n;
  endfunction

  function automatic int first(input int b, input int from);
    for (int i = from; i < NC; i++) if (tr_bits[i][b]) return i;
    return -1;
  endfunction

  // returns {NEWLINE, STROBEI, READYO, fbpending, FBSTROBE} for cycle c
  function automatic logic [4:0] stim(input int s, input int c);
    logic nl, stb, rdy, fbp, fbs;
    nl = 1'b0; stb = (c < 16); rdy = 1'b1; fbp = 1'b0; fbs = 1'b0;
    case (s)
      1: stb = stb | (c >= 67 && c < 83);
      2: rdy = !(c >= 51 && c <= 60);
      3: begin fbp = (c >= 50 && c <= 52); fbs = (c >= 53 && c <= 54); end
      4: fbp = 1'b1;
      5: begin nl = (c == 25); stb = (c < 16) || (c >= 27 && c < 43); end
      6: stb = stb | (c == 38);
      default: ;
    endcase
    return {nl, stb, rdy, fbp, fbs};
  endfunction

  // driver: reset (all other inputs asserted, reset must win), then n cycles
  task automatic run_scen(input int s, input int n);
    int viol;
    NEWLINE = 1'b1; STROBEI = 1'b1; READYO = 1'b1; fbpending = 1'b1; FBSTROBE = 1'b1;
    repeat (2) @(posedge CLK2);
    #1;
    chk($sformatf("s%0d_reset_outputs", s), 32'(snap()), 32'd0);
    chk($sformatf("s%0d_reset_idx", s), {sub_step, 2'b00, blk_idx, 3'b000, comp_idx}, 32'd0);
    for (int i = 0; i < NC; i++) begin
      tr_bits[i] = '0; tr_blk[i] = 0; tr_comp[i] = 0; tr_sub[i] = 0;
    end
    x8_cnt = 0; x8_max = 0;
    for (int c = 0; c < n; c++) begin
      {NEWLINE, STROBEI, READYO, fbpending, FBSTROBE} = stim(s, c);
      #1;
      tr_bits[c] = snap();
      tr_blk[c]  = int'(blk_idx);
      tr_comp[c] = int'(comp_idx);
      tr_sub[c]  = int'(sub_step);
      if (c < 67) begin
        if (en_xform8) x8_cnt++;
        if (int'(blk_idx8) > x8_max) x8_max = int'(blk_idx8);
      end
      @(posedge CLK2);
      #1;
    end
    viol = 0;
    for (int c = 0; c < n; c++)
      if ($countones(tr_bits[c][B_DONE:B_PRE]) != (tr_bits[c][B_BUSY] ? 1 : 0)) viol++;
    chk($sformatf("s%0d_phase_onehot", s), viol, 0);
  endtask

  initial begin
    // 4: feedback stuck high -> 64-cycle FB, sticky timeout, next block
    run_scen(4, 115);
    chk("s4_fb_len", cnt(B_FB, 42, 105), 64);
    chk("s4_fb_exit", tr_bits[106][B_FB], 0);
    chk("s4_wait_next", tr_bits[106][B_WAIT], 1);
    chk("s4_blk_next", tr_blk[106], 1);
    chk("s4_tmo_before", tr_bits[105][B_TMO], 0);
    chk("s4_tmo_set", tr_bits[106][B_TMO], 1);
    chk("s4_tmo_sticky", tr_bits[114][B_TMO], 1);

    // 1: nominal two-component run (reset above also clears fb_timeout)
    run_scen(1, 140);
    chk("s1_first_pre", first(B_PRE, 0), 16);
    chk("s1_pre_len", cnt(B_PRE, 16, 18), 3);
    chk("s1_pre_sub2", tr_sub[18], 2);
    chk("s1_first_xform", first(B_XF, 0), 19);
    chk("s1_xform_len", cnt(B_XF, 19, 34), 16);
    chk("s1_xf_sub3", tr_sub[22], 3);
    chk("s1_xf_blk1", tr_blk[23], 1);
    chk("s1_xf_blk3", tr_blk[34], 3);
    chk("s1_wait0_blk", tr_blk[35], 0);
    chk("s1_wait_sub", tr_sub[35], 0);
    chk("s1_wait_cnt", cnt(B_WAIT, 35, 66), 4);
    chk("s1_out_cnt", cnt(B_OUT, 35, 66), 24);
    chk("s1_fb_cnt", cnt(B_FB, 35, 66), 4);
    chk("s1_blk1_wait", tr_blk[43], 1);
    chk("s1_comp0", tr_comp[66], 0);
    chk("s1_comp1", tr_comp[67], 1);
    chk("s1_c1_pre", first(B_PRE, 67), 83);
    chk("s1_c1_xform", cnt(B_XF, 86, 101), 16);
    chk("s1_done_at", first(B_DONE, 0), 134);
    chk("s1_done_once", cnt(B_DONE, 0, 139), 1);
    chk("s1_comp_after", tr_comp[135], 0);
    chk("s1_loads", cnt(B_LOAD, 0, 139), 32);
    chk("s1_no_tmo", tr_bits[139][B_TMO], 0);
    chk("s1_no_ovr", tr_bits[139][B_OVR], 0);
    chk("s7_xform8_len", x8_cnt, 32);
    chk("s7_blk8_max", x8_max, 7);

    // 2: READYO low 10 cycles at WAITO of block 2
    run_scen(2, 80);
    chk("s2_wait_len", cnt(B_WAIT, 51, 61), 11);
    chk("s2_blk_hold", tr_blk[56], 2);
    chk("s2_out_start", first(B_OUT, 51), 62);

    // 3: feedback busy 5 cycles at FB of block 1
    run_scen(3, 70);
    chk("s3_fb_len", cnt(B_FB, 43, 60), 6);
    chk("s3_fb_last", tr_bits[55][B_FB], 1);
    chk("s3_wait", tr_bits[56][B_WAIT], 1);
    chk("s3_blk", tr_blk[56], 2);
    chk("s3_no_tmo", tr_bits[69][B_TMO], 0);

    // 5: reset mid-XFORM, then a clean restart
    run_scen(5, 60);
    chk("s5_blk_before", tr_blk[25], 1);
    chk("s5_outs_cleared", 32'(tr_bits[26]), 32'd0);
    chk("s5_idx_cleared", tr_blk[26] + tr_comp[26] + tr_sub[26], 0);
    chk("s5_pre_restart", first(B_PRE, 26), 43);
    chk("s5_pre_len", cnt(B_PRE, 43, 45), 3);
    chk("s5_xform_restart", first(B_XF, 26), 46);

    // 6: stray strobe during OUT
    run_scen(6, 70);
    chk("s6_ovr_before", tr_bits[38][B_OVR], 0);
    chk("s6_ovr_set", tr_bits[39][B_OVR], 1);
    chk("s6_ovr_sticky", tr_bits[69][B_OVR], 1);
    chk("s6_sub", tr_sub[39], 3);
    chk("s6_blk", tr_blk[39], 0);
    chk("s6_out_cnt", cnt(B_OUT, 35, 66), 24);
    chk("s6_fb_at", tr_bits[42][B_FB], 1);
    chk("s6_wait_at", tr_bits[43][B_WAIT], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
